// File: rtl/commit_stream_checker.sv
// commit_stream_checker: buffers the DUT and golden-model retire streams in two
// FIFOs, compares them head to head and reports pass/fail with the first
// divergent commit captured.

// Single-clock FIFO holding packed commit records; head is registered storage,
// so an entry becomes visible the cycle after it is pushed.
module commit_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Entry storage, written only on an accepted push.
    // NOTE: the storage array has no reset; count alone decides which slots are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module commit_stream_checker #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024,
    parameter int CMP_DATA   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            end_i,
    input  logic            dut_update_i,
    input  logic [XLEN-1:0] dut_pc_i,
    input  logic [31:0]     dut_instr_i,
    input  logic [4:0]      dut_reg_addr_i,
    input  logic [XLEN-1:0] dut_reg_data_i,
    input  logic            ref_update_i,
    input  logic [XLEN-1:0] ref_pc_i,
    input  logic [31:0]     ref_instr_i,
    input  logic [4:0]      ref_reg_addr_i,
    input  logic [XLEN-1:0] ref_reg_data_i,
    output logic            pass_o,
    output logic            fail_o,
    output logic [1:0]      fail_code_o,
    output logic [31:0]     commit_cnt_o,
    output logic [XLEN-1:0] fail_dut_pc_o,
    output logic [XLEN-1:0] fail_ref_pc_o,
    output logic [31:0]     fail_dut_instr_o,
    output logic [31:0]     fail_ref_instr_o
);
    // Record layout, MSB first: pc | instr | rd | rd_data
    localparam int EW  = 2 * XLEN + 37;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_OVERFLOW = 2'd3;

    typedef enum logic [1:0] {S_ACTIVE, S_DRAIN, S_PASS, S_FAIL} state_t;

    state_t          state;
    logic [WDW-1:0]  wd;
    logic            running;
    logic            dut_full, dut_empty, ref_full, ref_empty;
    logic [EW-1:0]   dut_head, ref_head;
    logic            do_cmp, entries_match;
    logic            ovf_evt, mism_evt, tmo_evt, fail_evt;

    logic [XLEN-1:0] dut_h_pc, ref_h_pc, dut_h_data, ref_h_data;
    logic [31:0]     dut_h_instr, ref_h_instr;
    logic [4:0]      dut_h_rd, ref_h_rd;

    // Streams are only accepted and compared while the verdict is still open.
    assign running = (state == S_ACTIVE) || (state == S_DRAIN);
    assign do_cmp  = running && !dut_empty && !ref_empty;

    commit_stream_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_dut_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (running && dut_update_i),
        .pop   (do_cmp),
        .din   ({dut_pc_i, dut_instr_i, dut_reg_addr_i, dut_reg_data_i}),
        .full  (dut_full),
        .empty (dut_empty),
        .head  (dut_head)
    );

    commit_stream_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (running && ref_update_i),
        .pop   (do_cmp),
        .din   ({ref_pc_i, ref_instr_i, ref_reg_addr_i, ref_reg_data_i}),
        .full  (ref_full),
        .empty (ref_empty),
        .head  (ref_head)
    );

    assign dut_h_pc    = dut_head[EW-1 -: XLEN];
    assign dut_h_instr = dut_head[XLEN+36 -: 32];
    assign dut_h_rd    = dut_head[XLEN+4 -: 5];
    assign dut_h_data  = dut_head[XLEN-1:0];
    assign ref_h_pc    = ref_head[EW-1 -: XLEN];
    assign ref_h_instr = ref_head[XLEN+36 -: 32];
    assign ref_h_rd    = ref_head[XLEN+4 -: 5];
    assign ref_h_data  = ref_head[XLEN-1:0];

    // rd == x0 writes nothing architecturally, so its data field is never compared.
    assign entries_match = (dut_h_pc == ref_h_pc) && (dut_h_instr == ref_h_instr) &&
                           (dut_h_rd == ref_h_rd) &&
                           ((CMP_DATA == 0) || (dut_h_rd == 5'd0) || (dut_h_data == ref_h_data));

    // A dropped entry can only happen on a full FIFO with no compare popping it.
    assign ovf_evt  = running && !do_cmp &&
                      ((dut_update_i && dut_full) || (ref_update_i && ref_full));
    assign mism_evt = do_cmp && !entries_match;
    assign tmo_evt  = running && (wd == WD_MAX);
    assign fail_evt = ovf_evt || mism_evt || tmo_evt;

    // Watchdog: counts cycles where one stream has work and the other has none.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd <= '0;
        end else if (running) begin
            // Equal emptiness means both idle or both present (which pops).
            if (dut_empty == ref_empty) wd <= '0;
            else if (wd != WD_MAX)      wd <= wd + 1'b1;
        end
    end

    // Verdict FSM with registered outputs, failure capture and commit counting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_ACTIVE;
            pass_o           <= 1'b0;
            fail_o           <= 1'b0;
            fail_code_o      <= '0;
            commit_cnt_o     <= '0;
            fail_dut_pc_o    <= '0;
            fail_ref_pc_o    <= '0;
            fail_dut_instr_o <= '0;
            fail_ref_instr_o <= '0;
        end else begin
            case (state)
                S_ACTIVE, S_DRAIN: begin
                    if (fail_evt) begin
                        state            <= S_FAIL;
                        fail_o           <= 1'b1;
                        fail_code_o      <= ovf_evt  ? FC_OVERFLOW :
                                            mism_evt ? FC_MISMATCH : FC_TIMEOUT;
                        fail_dut_pc_o    <= dut_empty ? '0 : dut_h_pc;
                        fail_ref_pc_o    <= ref_empty ? '0 : ref_h_pc;
                        fail_dut_instr_o <= dut_empty ? '0 : dut_h_instr;
                        fail_ref_instr_o <= ref_empty ? '0 : ref_h_instr;
                    end else begin
                        if (do_cmp) commit_cnt_o <= commit_cnt_o + 32'd1;
                        if (state == S_ACTIVE) begin
                            if (end_i) state <= S_DRAIN;
                        end else if (dut_empty && ref_empty) begin
                            state  <= S_PASS;
                            pass_o <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_commit_stream_checker.sv
// Self-checking bench for commit_stream_checker: table of single-pair compare
// vectors, directed multi-cycle scenarios and random traffic, all checked
// against a queue-based reference model of the checker.
module tb_commit_stream_checker;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        entry_t d;
        entry_t r;
        bit     match_full;
        bit     match_nodata;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst, end_p, du, ru;
    entry_t de, re;

    logic        pass_a, fail_a, pass_b, fail_b;
    logic [1:0]  code_a, code_b;
    logic [31:0] cnt_a, cnt_b;
    logic [31:0] fdpc_a, frpc_a, fdi_a, fri_a;
    logic [31:0] fdpc_b, frpc_b, fdi_b, fri_b;

    commit_stream_checker #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CMP_DATA(1)) u_main (
        .clk_i(clk), .rst_i(rst), .end_i(end_p),
        .dut_update_i(du), .dut_pc_i(de.pc), .dut_instr_i(de.instr),
        .dut_reg_addr_i(de.rd), .dut_reg_data_i(de.data),
        .ref_update_i(ru), .ref_pc_i(re.pc), .ref_instr_i(re.instr),
        .ref_reg_addr_i(re.rd), .ref_reg_data_i(re.data),
        .pass_o(pass_a), .fail_o(fail_a), .fail_code_o(code_a), .commit_cnt_o(cnt_a),
        .fail_dut_pc_o(fdpc_a), .fail_ref_pc_o(frpc_a),
        .fail_dut_instr_o(fdi_a), .fail_ref_instr_o(fri_a)
    );

    commit_stream_checker #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CMP_DATA(0)) u_nodata (
        .clk_i(clk), .rst_i(rst), .end_i(end_p),
        .dut_update_i(du), .dut_pc_i(de.pc), .dut_instr_i(de.instr),
        .dut_reg_addr_i(de.rd), .dut_reg_data_i(de.data),
        .ref_update_i(ru), .ref_pc_i(re.pc), .ref_instr_i(re.instr),
        .ref_reg_addr_i(re.rd), .ref_reg_data_i(re.data),
        .pass_o(pass_b), .fail_o(fail_b), .fail_code_o(code_b), .commit_cnt_o(cnt_b),
        .fail_dut_pc_o(fdpc_b), .fail_ref_pc_o(frpc_b),
        .fail_dut_instr_o(fdi_b), .fail_ref_instr_o(fri_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (CMP_DATA = 1 instance) ----------------
    localparam int M_ACTIVE = 0, M_DRAIN = 1, M_PASS = 2, M_FAIL = 3;
    entry_t      mdq[$];
    entry_t      mrq[$];
    int          m_state = M_ACTIVE;
    int          m_wd = 0;
    logic [31:0] m_cnt = '0;
    bit          m_pass = 0, m_fail = 0;
    logic [1:0]  m_code = '0;
    logic [31:0] m_fdpc = '0, m_frpc = '0, m_fdi = '0, m_fri = '0;

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit same, cmp, ovf, mism, tmo;
        int dn, rn;
        if (rst) begin
            mdq.delete(); mrq.delete();
            m_state = M_ACTIVE; m_wd = 0; m_cnt = '0; m_pass = 0; m_fail = 0; m_code = '0;
            m_fdpc = '0; m_frpc = '0; m_fdi = '0; m_fri = '0;
            return;
        end
        if (m_state == M_PASS || m_state == M_FAIL) return;
        dn = mdq.size();
        rn = mrq.size();
        cmp = (dn > 0) && (rn > 0);
        same = 1;
        if (cmp)
            same = (mdq[0].pc == mrq[0].pc) && (mdq[0].instr == mrq[0].instr) &&
                   (mdq[0].rd == mrq[0].rd) && (mdq[0].rd == 0 || mdq[0].data == mrq[0].data);
        ovf  = !cmp && ((du && dn == DEPTH) || (ru && rn == DEPTH));
        mism = cmp && !same;
        tmo  = (m_wd >= TIMEOUT);
        if (ovf || mism || tmo) begin
            m_state = M_FAIL;
            m_fail  = 1;
            m_code  = ovf ? 2'd3 : (mism ? 2'd1 : 2'd2);
            m_fdpc  = (dn > 0) ? mdq[0].pc    : 32'd0;
            m_frpc  = (rn > 0) ? mrq[0].pc    : 32'd0;
            m_fdi   = (dn > 0) ? mdq[0].instr : 32'd0;
            m_fri   = (rn > 0) ? mrq[0].instr : 32'd0;
            return;
        end
        if ((dn > 0) != (rn > 0)) m_wd = (m_wd < TIMEOUT) ? m_wd + 1 : TIMEOUT;
        else                      m_wd = 0;
        if (cmp) begin
            m_cnt = m_cnt + 1;
            void'(mdq.pop_front());
            void'(mrq.pop_front());
        end
        if (m_state == M_ACTIVE && end_p) m_state = M_DRAIN;
        else if (m_state == M_DRAIN && dn == 0 && rn == 0) begin
            m_state = M_PASS;
            m_pass  = 1;
        end
        if (du && mdq.size() < DEPTH) mdq.push_back(de);
        if (ru && mrq.size() < DEPTH) mrq.push_back(re);
    endtask

    task automatic compare_model();
        check("pass_o",           pass_a, m_pass);
        check("fail_o",           fail_a, m_fail);
        check("fail_code_o",      code_a, m_code);
        check("commit_cnt_o",     cnt_a,  m_cnt);
        check("fail_dut_pc_o",    fdpc_a, m_fdpc);
        check("fail_ref_pc_o",    frpc_a, m_frpc);
        check("fail_dut_instr_o", fdi_a,  m_fdi);
        check("fail_ref_instr_o", fri_a,  m_fri);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input bit pu, input entry_t d, input bit qu, input entry_t r, input bit e);
        du = pu; de = d; ru = qu; re = r; end_p = e;
        tick();
        du = 0; ru = 0; end_p = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        rst = 1; du = 0; ru = 0; end_p = 0; de = '0; re = '0;
        tick();
        rst = 0;
    endtask

    task automatic wait_done(input string name, input int limit, output int waited);
        waited = 0;
        while (!(pass_a || fail_a) && waited < limit) begin
            idle(1);
            waited++;
        end
        check({name, "_done_in_bound"}, pass_a | fail_a, 1);
    endtask

    function automatic entry_t mk_entry(input int i);
        entry_t e;
        e.pc    = 32'h0000_1000 + 32'(i) * 32'd4;
        e.instr = (32'(i) * 32'h0101_0101) ^ 32'h0000_0013;
        e.rd    = 5'(i * 7);
        e.data  = 32'(i) * 32'h9E37_79B9;
        return e;
    endfunction

    // ---------------- test sequence ----------------
    vec_t   vecs[7];
    entry_t base, d, r;
    int     waited, n, di, ri, cyc;
    bit     pu, qu;

    initial begin
        rst = 1; du = 0; ru = 0; end_p = 0; de = '0; re = '0;

        // Reset state
        do_reset();
        check("rst_pass", pass_a, 0);
        check("rst_fail", fail_a, 0);
        check("rst_code", code_a, 0);
        check("rst_cnt",  cnt_a,  0);
        check("rst_fdpc", fdpc_a, 0);
        check("rst_nd_pass", pass_b, 0);

        // Table of single commit pairs: which fields are allowed to differ
        base = mk_entry(5);
        for (int k = 0; k < 7; k++) begin
            vecs[k].d = base;
            vecs[k].r = base;
        end
        vecs[0].match_full = 1; vecs[0].match_nodata = 1;
        vecs[1].r.data ^= 32'h1;                                          vecs[1].match_full = 0; vecs[1].match_nodata = 1;
        vecs[2].d.rd = 0; vecs[2].r.rd = 0; vecs[2].r.data ^= 32'h1;      vecs[2].match_full = 1; vecs[2].match_nodata = 1;
        vecs[3].r.pc = base.pc + 32'd4;                                   vecs[3].match_full = 0; vecs[3].match_nodata = 0;
        vecs[4].r.instr ^= 32'h100;                                       vecs[4].match_full = 0; vecs[4].match_nodata = 0;
        vecs[5].r.rd = 5'd4;                                              vecs[5].match_full = 0; vecs[5].match_nodata = 0;
        vecs[6].d.rd = 5'd0; vecs[6].r.data ^= 32'h1;                     vecs[6].match_full = 0; vecs[6].match_nodata = 0;
        for (int k = 0; k < 7; k++) begin
            do_reset();
            drive(1, vecs[k].d, 1, vecs[k].r, 0);
            drive(0, '0, 0, '0, 1);
            idle(4);
            check($sformatf("vec%0d_pass", k),    pass_a, vecs[k].match_full);
            check($sformatf("vec%0d_code", k),    code_a, vecs[k].match_full ? 2'd0 : 2'd1);
            check($sformatf("vec%0d_cnt", k),     cnt_a,  vecs[k].match_full ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_fdpc", k),    fdpc_a, vecs[k].match_full ? 32'd0 : vecs[k].d.pc);
            check($sformatf("vec%0d_nd_pass", k), pass_b, vecs[k].match_nodata);
            check($sformatf("vec%0d_nd_code", k), code_b, vecs[k].match_nodata ? 2'd0 : 2'd1);
        end

        // 100 identical commits, golden stream 3 cycles behind
        do_reset();
        for (int c = 0; c < 103; c++)
            drive(c < 100, mk_entry(c), c >= 3, mk_entry(c - 3), 0);
        drive(0, '0, 0, '0, 1);
        wait_done("lag3", 20, waited);
        check("lag3_pass", pass_a, 1);
        check("lag3_fail", fail_a, 0);
        check("lag3_cnt",  cnt_a,  100);

        // Commit #37 data mismatch on x10, then the same with rd = x0
        for (int v = 0; v < 2; v++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                d = mk_entry(i);
                r = mk_entry(i);
                if (i == 36) begin
                    d.rd = (v == 0) ? 5'd10 : 5'd0;
                    r.rd = d.rd;
                    d.data = 32'h5;
                    r.data = 32'h6;
                end
                drive(1, d, 1, r, 0);
            end
            drive(0, '0, 0, '0, 1);
            idle(4);
            if (v == 0) begin
                check("mm_fail",  fail_a, 1);
                check("mm_code",  code_a, 1);
                check("mm_cnt",   cnt_a,  36);
                check("mm_fdpc",  fdpc_a, mk_entry(36).pc);
                check("mm_frpc",  frpc_a, mk_entry(36).pc);
            end else begin
                check("mm_x0_pass", pass_a, 1);
                check("mm_x0_cnt",  cnt_a,  40);
            end
            check($sformatf("mm%0d_nd_pass", v), pass_b, 1);
            check($sformatf("mm%0d_nd_cnt", v),  cnt_b,  40);
        end

        // Nine DUT pushes with the golden stream idle: the ninth overflows
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, mk_entry(i), 0, '0, 0);
        check("ovf_full_ok", fail_a, 0);
        drive(1, mk_entry(8), 0, '0, 0);
        check("ovf_fail", fail_a, 1);
        check("ovf_code", code_a, 3);
        check("ovf_fdpc", fdpc_a, mk_entry(0).pc);
        check("ovf_frpc", frpc_a, 0);

        // DUT 5 commits, golden 4, end: watchdog timeout
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, mk_entry(i), 1, mk_entry(i), 0);
        drive(1, mk_entry(4), 0, '0, 0);
        drive(0, '0, 0, '0, 1);
        wait_done("tmo", TIMEOUT + 20, waited);
        check("tmo_code", code_a, 2);
        check("tmo_cnt",  cnt_a,  4);
        check("tmo_not_early", waited >= TIMEOUT - 8, 1);
        check("tmo_fdpc", fdpc_a, mk_entry(4).pc);

        // Full DUT FIFO with push+pop every cycle, then reset mid-run
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, mk_entry(i), 0, '0, 0);
        drive(0, '0, 1, mk_entry(0), 0);
        for (int k = 0; k < 1000; k++) drive(1, mk_entry(8 + k), 1, mk_entry(1 + k), 0);
        check("full_pp_fail", fail_a, 0);
        check("full_pp_cnt",  cnt_a,  1000);
        rst = 1; du = 1; ru = 1; de = mk_entry(3000); re = mk_entry(3000);
        tick();
        rst = 0; du = 0; ru = 0;
        check("midrst_pass", pass_a, 0);
        check("midrst_fail", fail_a, 0);
        check("midrst_cnt",  cnt_a,  0);
        check("midrst_code", code_a, 0);
        for (int i = 0; i < 10; i++) drive(1, mk_entry(i), 1, mk_entry(i), 0);
        drive(0, '0, 0, '0, 1);
        wait_done("post_rst", 20, waited);
        check("post_rst_pass", pass_a, 1);
        check("post_rst_cnt",  cnt_a,  10);

        // Random traffic, occasional data corruption, checked against the model
        for (int run = 0; run < 8; run++) begin
            do_reset();
            n = $urandom_range(30, 80);
            di = 0; ri = 0; cyc = 0;
            while ((di < n || ri < n) && cyc < 8 * n) begin
                pu = (di < n) && ($urandom_range(0, 1) == 1);
                qu = (ri < n) && ($urandom_range(0, 1) == 1);
                d = mk_entry(di + run * 100);
                r = mk_entry(ri + run * 100);
                if ($urandom_range(0, 99) < 2) r.data ^= 32'h1;
                drive(pu, d, qu, r, 0);
                if (pu) di++;
                if (qu) ri++;
                cyc++;
            end
            drive(0, '0, 0, '0, 1);
            idle(30);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
